// File: rtl/bist_pkg.sv
// Shared definitions for the BIST session scheduler.
//   - default session count, pattern clocks per session, signature width
//   - scheduler FSM state encoding
//   - helper for sizing the session-select index
package bist_pkg;

    localparam int unsigned DEF_NSESS  = 4;
    localparam int unsigned DEF_NCLOCK = 650;
    localparam int unsigned DEF_SIG_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } bist_state_t;

    // Width of an index over n items; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bist_cycle_counter.sv
// Pattern-clock counter for one BIST session.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset
//   clear   - synchronous clear to zero (wins over enable)
//   enable  - count one pattern clock
//   tc      - terminal count: counter holds LIMIT-1, i.e. the last
//             pattern clock of the session is in progress
// The counter is LIMIT+1 states wide and saturates at LIMIT, so it
// can never wrap back into the active range.
module bist_cycle_counter
    import bist_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_NCLOCK
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(LIMIT))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bist_session_sched.sv
// BIST session scheduler.
// Sequences NSESS test sessions: for each session it pulses init to
// seed LFSR/MISR, enables the datapath for NCLOCK pattern clocks,
// then compares the MISR signature against that session's golden
// value. A run ends with a one-cycle done pulse and a pass verdict.
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   start        - run request, rising edge triggers (IDLE only)
//   halt_on_fail - end the run after the first failing session
//   misr_sig     - signature from the datapath MISR
//   golden_sigs  - expected signatures, session k at [k*SIG_W +: SIG_W]
//   sel          - current session / CUT index
//   init         - one-cycle seed/clear strobe
//   running      - pattern-clock enable
//   capture      - signature compare strobe
//   busy         - high whenever not idle
//   done         - one-cycle end-of-run strobe
//   pass         - run verdict, valid from done until next start
//   fail_map     - per-session mismatch flags
module bist_session_sched
    import bist_pkg::*;
#(
    parameter int unsigned NSESS  = DEF_NSESS,
    parameter int unsigned NCLOCK = DEF_NCLOCK,
    parameter int unsigned SIG_W  = DEF_SIG_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            halt_on_fail,
    input  logic [SIG_W-1:0]                misr_sig,
    input  logic [NSESS*SIG_W-1:0]          golden_sigs,
    output logic [sel_width(NSESS)-1:0]     sel,
    output logic                            init,
    output logic                            running,
    output logic                            capture,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [NSESS-1:0]                fail_map
);

    localparam int unsigned SEL_W = sel_width(NSESS);

    bist_state_t state;
    bist_state_t state_nxt;

    logic             start_d;
    logic             start_armed;
    logic             start_edge;
    logic             accept;
    logic             tc;
    logic             mismatch;
    logic             last_sess;
    logic             stop_run;
    logic [SIG_W-1:0] golden_cur;
    logic [NSESS-1:0] sel_onehot;
    logic [NSESS-1:0] fail_map_upd;

    // start_armed only sets once start has been seen low after reset,
    // so a start already high when reset releases cannot fake an edge
    // against the cleared start_d.
    assign start_edge = start && !start_d && start_armed;
    assign accept     = (state == ST_IDLE) && start_edge;

    // Golden slice and one-hot flag for the current session.
    always_comb begin
        golden_cur = '0;
        sel_onehot = '0;
        for (int unsigned k = 0; k < NSESS; k++) begin
            if (sel == SEL_W'(k)) begin
                golden_cur    = golden_sigs[k*SIG_W +: SIG_W];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    assign mismatch     = (misr_sig != golden_cur);
    assign last_sess    = (sel == SEL_W'(NSESS - 1));
    assign stop_run     = last_sess || (halt_on_fail && mismatch);
    assign fail_map_upd = fail_map | (mismatch ? sel_onehot : '0);

    bist_cycle_counter #(
        .LIMIT (NCLOCK)
    ) u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_INIT),
        .enable (state == ST_RUN),
        .tc     (tc)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start_edge) state_nxt = ST_INIT;
            ST_INIT:    state_nxt = ST_RUN;
            ST_RUN:     if (tc) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = stop_run ? ST_DONE : ST_INIT;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered state only) ----------------
    always_comb begin
        init    = 1'b0;
        running = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        unique case (state)
            ST_IDLE:    busy    = 1'b0;
            ST_INIT:    init    = 1'b1;
            ST_RUN:     running = 1'b1;
            ST_CAPTURE: capture = 1'b1;
            ST_DONE:    done    = 1'b1;
            default:    busy    = 1'b0;
        endcase
    end

    // ---------------- Run bookkeeping ----------------
    // pass is latched on the CAPTURE->DONE edge from the updated map so
    // the verdict is already valid while done is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_d     <= 1'b0;
            start_armed <= 1'b0;
            sel         <= '0;
            fail_map    <= '0;
            pass        <= 1'b0;
        end else begin
            start_d <= start;
            if (!start) begin
                start_armed <= 1'b1;
            end
            if (accept) begin
                sel      <= '0;
                fail_map <= '0;
                pass     <= 1'b0;
            end else if (state == ST_CAPTURE) begin
                fail_map <= fail_map_upd;
                if (stop_run) begin
                    pass <= (fail_map_upd == '0);
                end else begin
                    sel <= sel + SEL_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/bist_session_sched.md
BIST_SESSION_SCHED -- requirements
Module: bist_session_sched

Interface
REQ-001 Parameter NSESS, default 4, number of BIST sessions (CUT selections) run per start.
REQ-002 Parameter NCLOCK, default 650, pattern clocks per session.
REQ-003 Parameter SIG_W, default 16, MISR signature width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a full run; rising edge is the trigger.
REQ-007 halt_on_fail  input  1  stop after the first failing session.
REQ-008 misr_sig  input  SIG_W  signature from the datapath MISR.
REQ-009 golden_sigs  input  NSESS*SIG_W  expected signatures; slice k = bits [k*SIG_W +: SIG_W].
REQ-010 sel  output  $clog2(NSESS)  current session/CUT index.
REQ-011 init  output  1  one-cycle seed/clear pulse to LFSR and MISR.
REQ-012 running  output  1  pattern-clock enable to the datapath.
REQ-013 capture  output  1  signature compare strobe.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle end-of-run pulse.
REQ-016 pass  output  1  run verdict; valid from done until the next accepted start.
REQ-017 fail_map  output  NSESS  per-session mismatch flags.

Function
REQ-018 Start detection SHALL be a rising edge: start high and registered start_d low; a held-high start SHALL NOT retrigger.
REQ-019 A start edge SHALL be acted on only in IDLE; edges in any other state SHALL be ignored and not queued.
REQ-020 FSM states SHALL be IDLE, INIT, RUN, CAPTURE, DONE.
REQ-021 IDLE + start edge -> INIT next cycle; same edge SHALL clear sel to 0, fail_map to 0, pass to 0.
REQ-022 INIT SHALL last exactly 1 cycle with init=1, clear the pattern counter, and go to RUN.
REQ-023 RUN SHALL assert running for exactly NCLOCK consecutive cycles (counter 0..NCLOCK-1), then go to CAPTURE.
REQ-024 Pattern counter width SHALL be $clog2(NCLOCK+1) bits; the counter SHALL never wrap during RUN.
REQ-025 CAPTURE SHALL last 1 cycle with capture=1 and compare misr_sig against golden slice [sel]; on mismatch, fail_map[sel] SHALL be set on that edge.
REQ-026 CAPTURE -> DONE if sel==NSESS-1, or if halt_on_fail=1 and the current compare mismatches; otherwise sel increments and the FSM goes to INIT.
REQ-027 DONE SHALL last 1 cycle with done=1, latch pass = (final fail_map == 0), and go to IDLE.
REQ-028 sel, fail_map, and pass SHALL hold their values in IDLE until the next accepted start.
REQ-029 init, running, capture, and done SHALL be mutually exclusive and decoded from registered state, with no combinational path from inputs.
REQ-030 Per-session latency SHALL be NCLOCK+2 cycles; full-run latency from the start edge to done SHALL be NSESS*(NCLOCK+2)+1 cycles.

Reset
REQ-031 Reset low SHALL force IDLE, counter=0, sel=0, fail_map=0, pass=0, start_d=0, and all strobes 0 asynchronously, including mid-run.
REQ-032 After reset deasserts, a start that is already high SHALL NOT trigger a run; a new rising edge is required.

Structure
REQ-033 The FSM state encoding and default NCLOCK/NSESS/SIG_W SHALL live in shared package bist_pkg.
REQ-034 The pattern counter SHALL be a sub-module bist_cycle_counter (clear, enable, terminal-count output).

Verification (NSESS=4, NCLOCK=10, SIG_W=16)
REQ-035 All signatures match, one start pulse -> 4 init pulses, 10 running cycles each, done 49 cycles after the edge, pass=1, fail_map=0000.
REQ-036 Session 2 mismatches, halt_on_fail=0 -> run completes all 4 sessions, fail_map=0100, pass=0.
REQ-037 Session 1 mismatches, halt_on_fail=1 -> done after session 1 capture (25 cycles after the edge), fail_map=0010, sel=1.
REQ-038 start held high across the full run and into IDLE -> exactly one run; a start pulse during RUN is ignored.
REQ-039 reset low at RUN cycle 5 of session 2 -> immediate IDLE with all outputs 0; a subsequent start edge gives a clean full run.
